// File: rtl/tt_um_alu_completa.sv
// tt_um_alu_completa: 4-bit, 16-operation ALU in a Tiny Tapeout user tile.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous reset, ACTIVE-HIGH despite the name (harness-compatible name)
//   ena      tile enable; 0 holds result and flags
//   ui_in    [3:0] operand A, [7:4] operand B (unsigned)
//   uio_in   [3:0] opcode, [4] carry/borrow-in, [7:5] unused
//   uo_out   registered 8-bit result
//   uio_out  [7] V, [6] C, [5] Z (registered), [4:0] = 0
//   uio_oe   constant 8'hE0 (flag pins are outputs)
//
// Build option: define ALU_DIV_EN to synthesize the divider for opcode 3.
// Without it opcode 3 is illegal and returns R=0, Z=1, C=0, V=1.
module tt_um_alu_completa (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [3:0] a, b, op;
    logic       cin;
    logic [1:0] sh;

    assign a   = ui_in[3:0];
    assign b   = ui_in[7:4];
    assign op  = uio_in[3:0];
    assign cin = uio_in[4];
    assign sh  = b[1:0];

    // uio_in[7:5] are ignored by design.
    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:5]};

    // Signed 4-bit overflow: the exact signed result lies outside [-8, 7].
    function automatic logic ovf4(input logic signed [5:0] s);
        return (s > 6'sd7) || (s < -6'sd8);
    endfunction

    logic signed [5:0] sa, sb, scin;
    assign sa   = {{2{a[3]}}, a};
    assign sb   = {{2{b[3]}}, b};
    assign scin = {5'b0, cin};

    logic [4:0] sum5, dif5;
    logic [7:0] rot8;
    logic [3:0] shr_mask;

    assign sum5     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    // Unsigned 5-bit difference: bit 4 is set exactly when A < B + CIN.
    assign dif5     = {1'b0, a} - {1'b0, b} - {4'b0, cin};
    assign shr_mask = (4'b0001 << sh) - 4'b0001;

    logic [7:0] r_d, r_q;
    logic       c_d, c_q, v_d, v_q, z_d, z_q;

    always_comb begin
        r_d  = 8'h00;
        c_d  = 1'b0;
        v_d  = 1'b0;
        rot8 = 8'h00;
        unique case (op)
            4'h0: begin
                r_d = {3'b000, sum5};
                c_d = sum5[4];
                v_d = ovf4(sa + sb + scin);
            end
            4'h1: begin
                r_d = {4'h0, dif5[3:0]};
                c_d = dif5[4];
                v_d = ovf4(sa - sb - scin);
            end
            4'h2: r_d = {4'h0, a} * {4'h0, b};
            4'h3: begin
`ifdef ALU_DIV_EN
                if (b == 4'h0) begin
                    r_d = 8'hFF;
                    v_d = 1'b1;
                end else begin
                    r_d = {a % b, a / b};
                end
`else
                r_d = 8'h00;
                v_d = 1'b1;
`endif
            end
            4'h4: r_d = {4'h0, a & b};
            4'h5: r_d = {4'h0, a | b};
            4'h6: r_d = {4'h0, a ^ b};
            4'h7: r_d = {4'h0, ~a};
            4'h8: r_d = {4'h0, ~(a & b)};
            4'h9: r_d = {4'h0, ~(a | b)};
            4'hA: r_d = {4'h0, a} << sh;
            4'hB: begin
                r_d = {4'h0, a >> sh};
                c_d = |(a & shr_mask);
            end
            // Rotations use a doubled copy of A so the wrapped bits fall into place.
            4'hC: begin
                rot8 = {a, a} << sh;
                r_d  = {4'h0, rot8[7:4]};
            end
            4'hD: begin
                rot8 = {a, a} >> sh;
                r_d  = {4'h0, rot8[3:0]};
            end
            4'hE: r_d = {5'b0, a > b, a == b, a < b};
            4'hF: begin
                r_d = {4'h0, a + 4'h1};
                c_d = (a == 4'hF);
            end
            default: r_d = 8'h00;
        endcase
        z_d = (r_d == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_q <= 8'h00;
            c_q <= 1'b0;
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (ena) begin
            r_q <= r_d;
            c_q <= c_d;
            v_q <= v_d;
            z_q <= z_d;
        end
    end

    assign uo_out  = r_q;
    assign uio_out = {v_q, c_q, z_q, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_alu_completa.sv
// Testbench for tt_um_alu_completa: directed steps, expected outputs queued
// when each step is driven and compared after the following clock edge.
module tb_tt_um_alu_completa;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    tt_um_alu_completa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] FV = 8'h80;
    localparam logic [7:0] FC = 8'h40;
    localparam logic [7:0] FZ = 8'h20;

    // Drive one cycle's inputs on the falling edge, queue the expectation,
    // then check the registered outputs just after the next rising edge.
    task automatic step(input logic rst, input logic en, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] op, input logic cin,
                        input logic [7:0] exp_uo, input logic [7:0] exp_uio,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        ena    = en;
        ui_in  = {b, a};
        uio_in = {$urandom_range(0, 7), cin, op};
        e.uo = exp_uo;
        e.uio = exp_uio;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (uo_out === e.uo) else begin
            failures++;
            $error("FAIL %s uo_out observed=%02h expected=%02h", e.tag, uo_out, e.uo);
        end
        checks++;
        assert (uio_out === e.uio) else begin
            failures++;
            $error("FAIL %s uio_out observed=%02h expected=%02h", e.tag, uio_out, e.uio);
        end
        checks++;
        assert (uio_oe === 8'hE0) else begin
            failures++;
            $error("FAIL %s uio_oe observed=%02h expected=e0", e.tag, uio_oe);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with random operands and enable: outputs must stay cleared.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                 4'($urandom), 1'($urandom_range(0, 1)), 8'h00, 8'h00, "reset");

        step(1'b0, 1'b1, 4'h9, 4'h8, 4'h0, 1'b1, 8'h12, FV | FC, "add_9_8_c");
        step(1'b0, 1'b1, 4'h3, 4'h5, 4'h1, 1'b0, 8'h0E, FC,      "sub_3_5");
        step(1'b0, 1'b1, 4'h7, 4'h1, 4'h0, 1'b0, 8'h08, FV,      "add_7_1_ovf");
        step(1'b0, 1'b1, 4'hF, 4'hF, 4'h2, 1'b0, 8'hE1, 8'h00,   "mul_f_f");
`ifdef ALU_DIV_EN
        step(1'b0, 1'b1, 4'hD, 4'h4, 4'h3, 1'b0, 8'h13, 8'h00,   "div_13_4");
        step(1'b0, 1'b1, 4'h7, 4'h0, 4'h3, 1'b0, 8'hFF, FV,      "div_by_zero");
`else
        step(1'b0, 1'b1, 4'hD, 4'h4, 4'h3, 1'b0, 8'h00, FV | FZ, "div_illegal");
`endif
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'h4, 1'b0, 8'h02, 8'h00,   "and");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'h6, 1'b0, 8'h09, 8'h00,   "xor");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'h9, 1'b0, 8'h04, 8'h00,   "nor");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'h7, 1'b0, 8'h05, 8'h00,   "not");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'hA, 1'b0, 8'h50, 8'h00,   "shl");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'hB, 1'b0, 8'h01, FC,      "shr");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'hC, 1'b0, 8'h05, 8'h00,   "rol");
        step(1'b0, 1'b1, 4'h9, 4'h1, 4'hD, 1'b0, 8'h0C, 8'h00,   "ror_9_1");
        step(1'b0, 1'b1, 4'hA, 4'h3, 4'hD, 1'b0, 8'h05, 8'h00,   "ror_a_3");
        step(1'b0, 1'b1, 4'h5, 4'h5, 4'hE, 1'b0, 8'h02, 8'h00,   "cmp_eq");
        step(1'b0, 1'b1, 4'h2, 4'h9, 4'hE, 1'b0, 8'h01, 8'h00,   "cmp_lt");
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b0, 8'h00, FC | FZ, "inc_f");

        // Hold: result must survive three disabled cycles with changing inputs.
        step(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 8'h02, 8'h00,   "add_1_1");
        step(1'b0, 1'b0, 4'hF, 4'hF, 4'h2, 1'b1, 8'h02, 8'h00,   "hold_1");
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h02, 8'h00,   "hold_2");
        step(1'b0, 1'b0, 4'h3, 4'h0, 4'h3, 1'b0, 8'h02, 8'h00,   "hold_3");
        step(1'b1, 1'b0, 4'hF, 4'hF, 4'h2, 1'b0, 8'h00, 8'h00,   "reset_over_ena");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
